// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
// Shared encodings for the programmable modulo counter used on the UART timing
// path (baud, bit and sample counting).
//   MODE_*   : 2-bit counting mode. 2'b11 is reserved and behaves like WRAP.
//   os_state_e : one-shot controller states (IDLE / RUN).
//   DIR_*    : up_down encoding.
// -----------------------------------------------------------------------------
package mod_counter_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic {
      OS_IDLE = 1'b0,
      OS_RUN  = 1'b1
   } os_state_e;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_next.sv
// -----------------------------------------------------------------------------
// mod_counter_next
// Combinational step calculator for mod_counter. Given the current count, the
// range top, the direction and the mode it returns the value one enabled step
// would produce, whether that step actually moves the counter, and whether the
// result lands on the terminal value (limit when counting up, 0 when down).
// Ports:
//   count_i         in  WIDTH  current registered count
//   limit_i         in  WIDTH  top of the range [0, limit]
//   up_down_i       in  1      1 = up, 0 = down
//   mode_i          in  2      counting mode (see mod_counter_pkg)
//   next_count_o    out WIDTH  count after one step
//   hits_terminal_o out 1      step is taken and next_count equals terminal
//   can_step_o      out 1      0 when a saturating/one-shot counter is pinned
// -----------------------------------------------------------------------------
module mod_counter_next
   import mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic [WIDTH-1:0] limit_i,
   input  logic             up_down_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH-1:0] next_count_o,
   output logic             hits_terminal_o,
   output logic             can_step_o
);

   logic             wrap_mode;
   logic [WIDTH-1:0] terminal;

   // Reserved encoding 2'b11 falls through to WRAP; one-shot runs use the
   // saturating arithmetic so a finished run never rolls past its terminal.
   assign wrap_mode = (mode_i != MODE_SAT) && (mode_i != MODE_ONESHOT);
   assign terminal  = (up_down_i == DIR_UP) ? limit_i : '0;

   always_comb begin
      next_count_o = count_i;
      can_step_o   = 1'b1;

      if (up_down_i == DIR_UP) begin
         if (count_i >= limit_i) begin
            if (wrap_mode) begin
               next_count_o = '0;
            end else begin
               // Pinned at the top. If limit was lowered below the count,
               // pull the count back into range without calling it a step.
               next_count_o = limit_i;
               can_step_o   = 1'b0;
            end
         end else begin
            next_count_o = count_i + WIDTH'(1);
         end
      end else begin
         if (count_i == '0) begin
            if (wrap_mode) begin
               next_count_o = limit_i;
            end else begin
               can_step_o = 1'b0;
            end
         end else if (count_i > limit_i) begin
            // Limit was lowered under the count: re-enter the range at its top.
            next_count_o = limit_i;
         end else begin
            next_count_o = count_i - WIDTH'(1);
         end
      end
   end

   assign hits_terminal_o = can_step_o && (next_count_o == terminal);

endmodule : mod_counter_next

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Programmable modulo counter with WRAP, SATURATE and ONE_SHOT modes, parallel
// load, and a registered terminal pulse plus one-shot busy/done handshake so
// bit-period and frame-length timers need no external compare logic.
// Per-cycle priority: reset > clear > load > start > enabled step > hold.
// All outputs are registered (an event at edge N is visible after edge N).
// Ports:
//   clock       in  1      rising-edge clock
//   reset       in  1      synchronous, active-high
//   enable      in  1      one step per cycle when high
//   clear       in  1      count <= 0, one-shot -> IDLE
//   load        in  1      count <= min(load_value, limit), FSM unchanged
//   load_value  in  WIDTH  parallel load value
//   limit       in  WIDTH  top of range; terminal = limit (up) / 0 (down)
//   up_down     in  1      1 = up, 0 = down
//   mode        in  2      00 WRAP, 01 SATURATE, 10 ONE_SHOT, 11 = WRAP
//   start       in  1      arms / restarts the one-shot (ONE_SHOT mode only)
//   count_out   out WIDTH  registered count
//   tc_pulse    out 1      1-cycle pulse: an enabled step landed on terminal
//   busy        out 1      one-shot running
//   done        out 1      1-cycle pulse: one-shot reached terminal
//   dbg_state   out 1      one-shot controller state, for observation only
// -----------------------------------------------------------------------------
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int unsigned     WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] limit,
   input  logic             up_down,
   input  logic [1:0]       mode,
   input  logic             start,
   output logic [WIDTH-1:0] count_out,
   output logic             tc_pulse,
   output logic             busy,
   output logic             done,
   output os_state_e        dbg_state
);

   os_state_e        state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_count;
   logic             step_hits;
   logic             step_ok;
   logic             oneshot_mode;

   assign oneshot_mode = (mode == MODE_ONESHOT);

   mod_counter_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .count_i         (count_q),
      .limit_i         (limit),
      .up_down_i       (up_down),
      .mode_i          (mode),
      .next_count_o    (step_count),
      .hits_terminal_o (step_hits),
      .can_step_o      (step_ok)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      done_d  = 1'b0;

      if (clear) begin
         count_d = '0;
         state_d = OS_IDLE;
      end else begin
         // Leaving ONE_SHOT mode abandons a run silently (no done).
         if (!oneshot_mode) begin
            state_d = OS_IDLE;
         end

         if (load) begin
            count_d = (load_value > limit) ? limit : load_value;
         end else if (start && oneshot_mode) begin
            // Arm or restart: reload the start value, no step this cycle.
            count_d = (up_down == DIR_UP) ? '0 : limit;
            state_d = OS_RUN;
         end else if (enable) begin
            if (oneshot_mode) begin
               if (state_q == OS_RUN) begin
                  if (step_ok) begin
                     count_d = step_count;
                     tc_d    = step_hits;
                     if (step_hits) begin
                        state_d = OS_IDLE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     // Count was already parked on terminal (e.g. loaded
                     // there mid-run): the run is over, but no step happened.
                     state_d = OS_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end else if (step_ok) begin
               count_d = step_count;
               tc_d    = step_hits;
            end
         end
      end

      busy_d = (state_d == OS_RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= OS_IDLE;
         count_q <= RESET_VALUE;
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign count_out = count_q;
   assign tc_pulse  = tc_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
module tb_mod_counter;
   import mod_counter_pkg::*;

   localparam int W  = 4;
   localparam int EW = W + 3;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic          load = 1'b0;
   logic [W-1:0]  load_value = '0;
   logic [W-1:0]  limit = '0;
   logic          up_down = 1'b1;
   logic [1:0]    mode = MODE_WRAP;
   logic          start = 1'b0;
   logic [W-1:0]  count_out;
   logic          tc_pulse;
   logic          busy;
   logic          done;
   os_state_e     dbg_state;

   // expected word: {count, tc_pulse, busy, done}
   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;

   mod_counter #(
      .WIDTH       (W),
      .RESET_VALUE (4'd0)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .clear      (clear),
      .load       (load),
      .load_value (load_value),
      .limit      (limit),
      .up_down    (up_down),
      .mode       (mode),
      .start      (start),
      .count_out  (count_out),
      .tc_pulse   (tc_pulse),
      .busy       (busy),
      .done       (done),
      .dbg_state  (dbg_state)
   );

   // clock / watchdog
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // driver: inputs already set by caller; one edge, then publish expectation
   task automatic tick(input logic [W-1:0] ec, input logic et, input logic eb, input logic ed);
      @(posedge clock);
      exp_q.push_back({ec, et, eb, ed});
      cyc++;
      #1;
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: actual=%0d required=%0d (state=%0d)", name, cyc, act, req, dbg_state);
      end
   endtask

   // monitor / scoreboard: outputs are valid every cycle, sampled on negedge
   always @(negedge clock) begin
      if (exp_q.size() != 0) begin
         logic [EW-1:0] e;
         e = exp_q.pop_front();
         check("count", count_out, e[EW-1:3]);
         check("tc_pulse", {{(W-1){1'b0}}, tc_pulse}, {{(W-1){1'b0}}, e[2]});
         check("busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, e[1]});
         check("done", {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, e[0]});
      end
   end

   initial begin
      // reset
      reset = 1'b1;
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      reset = 1'b0;

      // 1: WRAP up, limit 5
      mode = MODE_WRAP; up_down = 1'b1; limit = 4'd5; enable = 1'b1;
      tick(1, 0, 0, 0); tick(2, 0, 0, 0); tick(3, 0, 0, 0); tick(4, 0, 0, 0);
      tick(5, 1, 0, 0); tick(0, 0, 0, 0); tick(1, 0, 0, 0); tick(2, 0, 0, 0);
      enable = 1'b0;
      tick(2, 0, 0, 0);

      // 2: SATURATE down from load 3
      mode = MODE_SAT; up_down = 1'b0; load = 1'b1; load_value = 4'd3;
      tick(3, 0, 0, 0);
      load = 1'b0; enable = 1'b1;
      tick(2, 0, 0, 0); tick(1, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
      enable = 1'b0;

      // SATURATE up pins at limit
      up_down = 1'b1; limit = 4'd2; load = 1'b1; load_value = 4'd1;
      tick(1, 0, 0, 0);
      load = 1'b0; enable = 1'b1;
      tick(2, 1, 0, 0); tick(2, 0, 0, 0);
      enable = 1'b0;

      // 3: ONE_SHOT up, limit 3
      mode = MODE_ONESHOT; limit = 4'd3; start = 1'b1;
      tick(0, 0, 1, 0);
      start = 1'b0; enable = 1'b1;
      tick(1, 0, 1, 0); tick(2, 0, 1, 0); tick(3, 1, 0, 1); tick(3, 0, 0, 0); tick(3, 0, 0, 0);
      enable = 1'b0;

      // 4: restart mid-run, then clear mid-run
      start = 1'b1;
      tick(0, 0, 1, 0);
      start = 1'b0; enable = 1'b1;
      tick(1, 0, 1, 0); tick(2, 0, 1, 0);
      start = 1'b1;
      tick(0, 0, 1, 0);
      start = 1'b0;
      tick(1, 0, 1, 0);
      clear = 1'b1;
      tick(0, 0, 0, 0);
      clear = 1'b0;
      tick(0, 0, 0, 0);
      enable = 1'b0;

      // mode leaves ONE_SHOT while running
      start = 1'b1;
      tick(0, 0, 1, 0);
      start = 1'b0; enable = 1'b1;
      tick(1, 0, 1, 0);
      mode = MODE_WRAP;
      tick(2, 0, 0, 0);
      enable = 1'b0;

      // 5: priority load > start > step, then reset over clear+load
      mode = MODE_ONESHOT; limit = 4'd6; load = 1'b1; load_value = 4'd9;
      enable = 1'b1; start = 1'b1;
      tick(6, 0, 0, 0);
      reset = 1'b1; clear = 1'b1;
      tick(0, 0, 0, 0);
      reset = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0; enable = 1'b0;

      // 6: limit = 0 in WRAP pulses every enabled cycle
      mode = MODE_WRAP; limit = 4'd0; up_down = 1'b1; enable = 1'b1;
      tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
      up_down = 1'b0;
      tick(0, 1, 0, 0);
      enable = 1'b0;

      // limit lowered 10 -> 4 at count 7, counting up
      up_down = 1'b1; limit = 4'd10; load = 1'b1; load_value = 4'd7;
      tick(7, 0, 0, 0);
      load = 1'b0; limit = 4'd4; enable = 1'b1;
      tick(0, 0, 0, 0); tick(1, 0, 0, 0);

      // WRAP down through 0 back to limit
      up_down = 1'b0;
      tick(0, 1, 0, 0); tick(4, 0, 0, 0); tick(3, 0, 0, 0);
      enable = 1'b0;

      // drain scoreboard with a bounded wait
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clock);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mod_counter
